csla_share_arb: RTL

Round-robin arbiter and two-stage pipeline controller that shares one 16-bit carry-select adder among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the operands and feeds them to the adder. It registers the mod-2^16 sum with the winner's ID and holds it under backpressure. It sits between the requesting datapath blocks and the adder, so the adder never needs to be duplicated.

---
 rtl/csla_pkg.sv | 33 +++
 rtl/cslawoc.sv | 29 ++
 rtl/csla_share_arb.sv | 108 ++++++++++
 3 files changed

// File: rtl/csla_pkg.sv
// Shared types and the round-robin pick helper for the shared carry-select adder arbiter.
package csla_pkg;

  localparam int DW     = 16;
  localparam int MAXREQ = 8;

  typedef logic [DW-1:0] opnd_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Scans ptr, ptr+1, ... modulo nreq and returns the first set bit of valid.
  function automatic pick_t rr_pick(input logic [MAXREQ-1:0] valid,
                                    input logic [2:0]        ptr,
                                    input int                nreq);
    pick_t r;
    int    j;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int k = 0; k < MAXREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= nreq) j = j - nreq;
      if ((k < nreq) && !r.found && valid[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cslawoc.sv
// 16-bit carry-select adder without carry-out: 4-bit blocks, each upper block
// precomputes both carry-in cases and the incoming carry selects between them.
module cslawoc
  import csla_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum
);

  logic [4:0] s0;
  logic [4:0] s1;
  logic       c;

  // Block-wise select chain; the final carry is intentionally dropped.
  always_comb begin
    s0  = '0;
    s1  = '0;
    c   = 1'b0;
    sum = '0;
    for (int blk = 0; blk < DW / 4; blk++) begin
      s0 = {1'b0, a[blk*4 +: 4]} + {1'b0, b[blk*4 +: 4]};
      s1 = s0 + 5'd1;
      sum[blk*4 +: 4] = c ? s1[3:0] : s0[3:0];
      c = c ? s1[4] : s0[4];
    end
  end

endmodule

// File: rtl/csla_share_arb.sv
// Round-robin arbiter plus two-stage pipeline sharing one carry-select adder
// among NREQ requesters. S1 holds the granted operands, S2 the registered sum.
module csla_share_arb
  import csla_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DW-1:0]        rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          done_cnt
);

  logic              s1_v_q, s1_v_d;
  opnd_t             s1_a_q, s1_a_d;
  opnd_t             s1_b_q, s1_b_d;
  logic [IDW-1:0]    s1_id_q, s1_id_d;
  logic              s2_v_q, s2_v_d;
  opnd_t             s2_sum_q, s2_sum_d;
  logic [IDW-1:0]    s2_id_q, s2_id_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [15:0]       done_cnt_q, done_cnt_d;

  logic [MAXREQ-1:0] valid_ext;
  logic [2:0]        ptr_ext;
  pick_t             pick;
  logic [IDW-1:0]    win;
  logic              adv2, acc, grant, fire;
  opnd_t             add_sum;

  cslawoc u_add (
    .a   (s1_a_q),
    .b   (s1_b_q),
    .sum (add_sum)
  );

  // Grant selection, handshake control and next-state for both stages.
  always_comb begin
    valid_ext               = '0;
    valid_ext[NREQ-1:0]     = req_valid;
    ptr_ext                 = '0;
    ptr_ext[IDW-1:0]        = ptr_q;
    pick                    = rr_pick(valid_ext, ptr_ext, NREQ);
    win                     = IDW'(pick.idx);

    adv2  = s1_v_q & (~s2_v_q | rsp_ready);
    acc   = ~s1_v_q | adv2;
    grant = pick.found & acc;
    fire  = s2_v_q & rsp_ready;

    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;

    s1_v_d  = grant ? 1'b1 : (adv2 ? 1'b0 : s1_v_q);
    s1_a_d  = grant ? req_a[int'(win)*DW +: DW] : s1_a_q;
    s1_b_d  = grant ? req_b[int'(win)*DW +: DW] : s1_b_q;
    s1_id_d = grant ? win : s1_id_q;

    ptr_d = ptr_q;
    if (grant) ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

    s2_v_d   = adv2 ? 1'b1 : (fire ? 1'b0 : s2_v_q);
    s2_sum_d = adv2 ? add_sum : s2_sum_q;
    s2_id_d  = adv2 ? s1_id_q : s2_id_q;

    done_cnt_d = fire ? done_cnt_q + 16'd1 : done_cnt_q;
  end

  // Control state and response registers, cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_sum_q   <= '0;
      s2_id_q    <= '0;
      ptr_q      <= '0;
      done_cnt_q <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      s2_sum_q   <= s2_sum_d;
      s2_id_q    <= s2_id_d;
      ptr_q      <= ptr_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // S1 operand payload; qualified by s1_v_q so it needs no reset.
  always_ff @(posedge clk) begin
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_id_q <= s1_id_d;
  end

  assign rsp_valid = s2_v_q;
  assign rsp_sum   = s2_sum_q;
  assign rsp_id    = s2_id_q;
  assign done_cnt  = done_cnt_q;

endmodule
